// File: rtl/axis8_word_arbiter.sv
// Round-robin byte-stream arbiter feeding one 8->32 packer.
// Grants are held for whole words so bytes of a word never mix.
module axis8_word_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int BYTES_PER_WORD = 4,
    parameter int BURST_WORDS    = 1,
    parameter int IDW            = 2
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic [NUM_SRC*8-1:0] m_data,
    input  logic [NUM_SRC-1:0]   m_valid,
    output logic [NUM_SRC-1:0]   m_ready,
    input  logic [NUM_SRC-1:0]   src_en,
    output logic [7:0]           s_data,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [IDW-1:0]       s_id,
    output logic                 s_first,
    output logic                 busy
);

    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t state, state_nxt;

    logic [IDW-1:0] gnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_inc;
    logic [IDW-1:0] win;
    logic [BW-1:0]  byte_cnt;
    logic [7:0]     word_cnt;

    logic [NUM_SRC-1:0][7:0] m_bytes;
    logic [NUM_SRC-1:0]      req;
    logic [2*NUM_SRC-1:0]    req2;
    logic [NUM_SRC-1:0]      rot;
    logic                    win_vld;
    int                      win_off;
    int                      win_sum;

    logic xfer;
    logic last_byte;
    logic last_word;
    logic rel;

    assign m_bytes = m_data;
    assign req     = m_valid & src_en;

    // Rotate requests so bit k is source (rr_ptr + k) mod NUM_SRC.
    assign req2 = {req, req};
    assign rot  = NUM_SRC'(req2 >> rr_ptr);

    // Lowest set bit of the rotated request wins.
    always_comb begin
        win_off = 0;
        win_vld = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_off = k;
                win_vld = 1'b1;
            end
        end
    end

    assign win_sum = int'(rr_ptr) + win_off;
    assign win = IDW'((win_sum >= NUM_SRC) ? win_sum - NUM_SRC : win_sum);

    assign gnt_inc = (gnt == IDW'(NUM_SRC - 1)) ? '0 : gnt + IDW'(1);

    assign xfer      = s_valid & s_ready;
    assign last_byte = (byte_cnt == BW'(BYTES_PER_WORD - 1));
    assign last_word = (word_cnt == 8'(BURST_WORDS - 1));
    assign rel       = xfer & last_byte &
                       (last_word | ~src_en[gnt] | ~m_valid[gnt]);

    // State register.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: one bubble to arbitrate, leave only at a word boundary.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (win_vld) state_nxt = GRANT;
            GRANT:   if (rel)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, pointer and byte/word counters.
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
        end else if (state == IDLE) begin
            if (win_vld) begin
                gnt      <= win;
                byte_cnt <= '0;
                word_cnt <= '0;
            end
        end else if (xfer) begin
            if (last_byte) begin
                byte_cnt <= '0;
                word_cnt <= rel ? 8'd0 : word_cnt + 8'd1;
            end else begin
                byte_cnt <= byte_cnt + BW'(1);
            end
            if (rel) rr_ptr <= gnt_inc;
        end
    end

    // Zero-latency steering of the granted source onto the packer port.
    always_comb begin
        s_valid = 1'b0;
        s_data  = '0;
        s_id    = '0;
        s_first = 1'b0;
        busy    = 1'b0;
        m_ready = '0;
        if (state == GRANT) begin
            s_valid      = m_valid[gnt];
            s_data       = m_bytes[gnt];
            s_id         = gnt;
            s_first      = (byte_cnt == '0);
            busy         = 1'b1;
            m_ready[gnt] = s_ready;
        end
    end

endmodule

// File: tb/tb_axis8_word_arbiter.sv
// Directed bench for axis8_word_arbiter.
// Second instance runs with two-word bursts.
module tb_axis8_word_arbiter;

    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] m_data;
    logic [3:0]  m_valid;
    logic [3:0]  src_en;
    logic        s_ready;

    logic [3:0]  m_ready, m_ready2;
    logic [7:0]  s_data, s_data2;
    logic        s_valid, s_valid2;
    logic [1:0]  s_id, s_id2;
    logic        s_first, s_first2;
    logic        busy, busy2;

    int checks = 0;
    int errors = 0;

    logic [7:0] seq [4];

    always #5 clk = ~clk;

    axis8_word_arbiter dut (
        .clk     (clk),
        .rstf    (rstf),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .src_en  (src_en),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_id    (s_id),
        .s_first (s_first),
        .busy    (busy)
    );

    axis8_word_arbiter #(.BURST_WORDS(2)) dut2 (
        .clk     (clk),
        .rstf    (rstf),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready2),
        .src_en  (src_en),
        .s_data  (s_data2),
        .s_valid (s_valid2),
        .s_ready (s_ready),
        .s_id    (s_id2),
        .s_first (s_first2),
        .busy    (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rstf = 1'b0;
        #1;
        rstf = 1'b1;
    endtask

    initial begin
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        seq[3] = 8'h44;
        m_data  = '0;
        m_valid = '0;
        src_en  = '0;
        s_ready = 1'b1;
        rstf    = 1'b0;

        // reset state
        #12;
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_m_ready", 32'(m_ready), 0);
        chk("rst_s_id", 32'(s_id), 0);
        chk("rst_s_first", 32'(s_first), 0);
        chk("rst_busy", 32'(busy), 0);
        rstf = 1'b1;
        tick();

        // single source 2
        src_en  = 4'b0100;
        m_valid = 4'b0100;
        m_data[23:16] = 8'h11;
        #1;
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_valid", 32'(s_valid), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            m_data[23:16] = seq[i];
            #1;
            chk("t1_valid", 32'(s_valid), 1);
            chk("t1_data", 32'(s_data), 32'(seq[i]));
            chk("t1_id", 32'(s_id), 2);
            chk("t1_first", 32'(s_first), 32'(i == 0));
            chk("t1_m_ready", 32'(m_ready), 32'h4);
            tick();
        end
        m_valid = '0;
        #1;
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_rr_ptr", 32'(dut.rr_ptr), 3);

        // round-robin contention
        pulse_reset();
        src_en  = 4'hF;
        m_valid = 4'hF;
        m_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("t2_bubble", 32'(busy), 0);
            tick();
            for (int b = 0; b < 4; b++) begin
                chk("t2_id", 32'(s_id), 32'(g % 4));
                chk("t2_data", 32'(s_data), 32'h A0 + 32'(g % 4));
                chk("t2_first", 32'(s_first), 32'(b == 0));
                chk("t2_m_ready", 32'(m_ready), 32'(1 << (g % 4)));
                tick();
            end
        end
        m_valid = '0;

        // two-word bursts
        pulse_reset();
        src_en  = 4'b0011;
        m_valid = 4'b0011;
        m_data  = {8'h00, 8'h00, 8'hB1, 8'hB0};
        #1;
        chk("t3_idle", 32'(busy2), 0);
        tick();
        chk("t3_wc0", 32'(dut2.word_cnt), 0);
        for (int b = 0; b < 8; b++) begin
            chk("t3_id0", 32'(s_id2), 0);
            chk("t3_data0", 32'(s_data2), 32'hB0);
            chk("t3_first0", 32'(s_first2), 32'(b % 4 == 0));
            tick();
        end
        chk("t3_bubble", 32'(busy2), 0);
        tick();
        chk("t3_wc1", 32'(dut2.word_cnt), 0);
        for (int b = 0; b < 8; b++) begin
            chk("t3_id1", 32'(s_id2), 1);
            chk("t3_data1", 32'(s_data2), 32'hB1);
            tick();
        end
        chk("t3_done", 32'(busy2), 0);
        m_valid = '0;

        // backpressure and source stall
        pulse_reset();
        src_en  = 4'b0010;
        m_valid = 4'b0010;
        m_data[15:8] = 8'h51;
        #1;
        chk("t4_idle", 32'(busy), 0);
        tick();
        chk("t4_b0", 32'(s_data), 32'h51);
        chk("t4_first", 32'(s_first), 1);
        chk("t4_id", 32'(s_id), 1);
        tick();
        m_data[15:8] = 8'h52;
        #1;
        chk("t4_b1", 32'(s_data), 32'h52);
        chk("t4_nfirst", 32'(s_first), 0);
        tick();
        m_valid = 4'b1101;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t4_stall_valid", 32'(s_valid), 0);
            chk("t4_stall_busy", 32'(busy), 1);
            chk("t4_stall_cnt", 32'(dut.byte_cnt), 2);
            chk("t4_stall_rdy", 32'(m_ready), 32'h2);
            tick();
        end
        m_valid = 4'b0010;
        m_data[15:8] = 8'h53;
        s_ready = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("t4_bp_valid", 32'(s_valid), 1);
            chk("t4_bp_rdy", 32'(m_ready), 0);
            chk("t4_bp_cnt", 32'(dut.byte_cnt), 2);
            tick();
        end
        s_ready = 1'b1;
        #1;
        chk("t4_b2", 32'(s_data), 32'h53);
        chk("t4_b2_rdy", 32'(m_ready), 32'h2);
        tick();
        m_data[15:8] = 8'h54;
        #1;
        chk("t4_b3", 32'(s_data), 32'h54);
        chk("t4_b3_cnt", 32'(dut.byte_cnt), 3);
        tick();
        m_valid = '0;
        #1;
        chk("t4_release", 32'(busy), 0);

        // enable dropped mid-word
        src_en  = 4'b1000;
        m_valid = 4'b1000;
        m_data[31:24] = 8'h61;
        #1;
        chk("t5_idle", 32'(busy), 0);
        tick();
        chk("t5_id", 32'(s_id), 3);
        chk("t5_b0", 32'(s_data), 32'h61);
        tick();
        m_data[31:24] = 8'h62;
        #1;
        chk("t5_b1", 32'(s_data), 32'h62);
        tick();
        src_en = '0;
        m_data[31:24] = 8'h63;
        #1;
        chk("t5_b2_valid", 32'(s_valid), 1);
        chk("t5_b2", 32'(s_data), 32'h63);
        chk("t5_b2_rdy", 32'(m_ready), 32'h8);
        tick();
        m_data[31:24] = 8'h64;
        #1;
        chk("t5_b3", 32'(s_data), 32'h64);
        chk("t5_b3_busy", 32'(busy), 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("t5_no_regrant", 32'(busy), 0);
            chk("t5_no_valid", 32'(s_valid), 0);
            tick();
        end
        m_valid = '0;

        // reset in the middle of a word
        src_en  = 4'b0011;
        m_valid = 4'b0010;
        m_data[15:8] = 8'h71;
        m_data[7:0]  = 8'h81;
        #1;
        chk("t6_idle", 32'(busy), 0);
        tick();
        chk("t6_id", 32'(s_id), 1);
        tick();
        m_data[15:8] = 8'h72;
        #1;
        chk("t6_b1", 32'(s_data), 32'h72);
        tick();
        m_data[15:8] = 8'h73;
        rstf = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(s_valid), 0);
        chk("t6_rst_rdy", 32'(m_ready), 0);
        chk("t6_rst_id", 32'(s_id), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ptr", 32'(dut.rr_ptr), 0);
        chk("t6_rst_cnt", 32'(dut.byte_cnt), 0);
        m_valid = 4'b0011;
        rstf = 1'b1;
        #1;
        chk("t6_post_idle", 32'(busy), 0);
        tick();
        chk("t6_regrant_busy", 32'(busy), 1);
        chk("t6_regrant_id", 32'(s_id), 0);
        chk("t6_regrant_data", 32'(s_data), 32'h81);
        m_valid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis8_word_arbiter.md
Name: axis8_word_arbiter

Overview:
Shares one 8-bit-to-32-bit AXI-stream packer between NUM_SRC independent byte-stream sources. Grants are round-robin, and each grant is held for whole 32-bit words, so the bytes of one word never mix between sources. The block sits directly upstream of the packer's 8-bit input. It presents the granted source's index on s_id so downstream logic can tag the packed word.

Parameters:
NUM_SRC, 4, number of byte-stream sources (2..16)
BYTES_PER_WORD, 4, bytes per packed word; must match the downstream packer
BURST_WORDS, 1, maximum words forwarded per grant before re-arbitration (1..255)
IDW, 2, width of s_id; must be >= clog2(NUM_SRC)

Ports:
clk  input  1  clock
rstf  input  1  reset; asynchronous, active-low
m_data  input  NUM_SRC*8  source byte data; source i occupies bits [8i+7:8i]
m_valid  input  NUM_SRC  per-source valid
m_ready  output  NUM_SRC  per-source ready
src_en  input  NUM_SRC  per-source enable mask (quasi-static configuration)
s_data  output  8  byte to packer
s_valid  output  1  byte valid to packer
s_ready  input  1  packer ready
s_id  output  IDW  index of the granted source; stable for the whole grant
s_first  output  1  high while the presented byte is byte 0 of a word
busy  output  1  high in GRANT state

Behaviour:
- Reset (rstf low, asynchronous): state = IDLE, rr_ptr = 0, byte_cnt = 0, word_cnt = 0, gnt = 0. Outputs: s_valid = 0, m_ready = all 0, s_id = 0, s_first = 0, busy = 0.
- A byte transfer occurs in a cycle where s_valid and s_ready are both high.
- State IDLE:
  - req = m_valid & src_en.
  - If req is nonzero, the winner is the first set bit scanning from rr_ptr upward, modulo NUM_SRC.
  - On the next edge: gnt = winner, state = GRANT, byte_cnt = 0, word_cnt = 0.
  - In IDLE, s_valid = 0 and m_ready = 0.
  - Arbitration costs exactly one bubble cycle.
- State GRANT:
  - s_data = m_data[gnt]; s_valid = m_valid[gnt]; m_ready[gnt] = s_ready; all other m_ready bits = 0. This path is combinational, with zero latency.
  - s_id = gnt; s_first = (byte_cnt == 0); busy = 1.
  - On each transfer, byte_cnt increments. At BYTES_PER_WORD-1 it wraps to 0 and word_cnt increments.
- Release from GRANT: occurs only at a word boundary, i.e. on the transfer with byte_cnt == BYTES_PER_WORD-1. It happens if either of the following holds:
  - word_cnt == BURST_WORDS-1; or
  - src_en[gnt] == 0 or m_valid[gnt] == 0 at that cycle. This is an early release; a source that is idle after a word does not hold the packer.
- On release: state = IDLE, rr_ptr = (gnt+1) mod NUM_SRC. The previous winner gets lowest priority in the next arbitration.
- Mid-word deassertion:
  - src_en[gnt] falling mid-word is ignored until the word completes (word integrity over configuration).
  - m_valid[gnt] falling mid-word simply stalls the word; the grant is held indefinitely. No timeout.
- Backpressure: s_ready low stalls byte_cnt and word_cnt. No state change and no data loss.
- Wrap-around: rr_ptr and the winner scan wrap modulo NUM_SRC. byte_cnt and word_cnt never exceed their terminal values.
- Reset mid-word: the partial word is discarded by this block. The downstream packer shares rstf and therefore clears its partial word too.
- Non-power-of-two NUM_SRC: scan and rr_ptr increments are modulo NUM_SRC. gnt never holds a value >= NUM_SRC.
- src_en and m_valid changes on non-granted sources have no effect while in GRANT.

Test Plan:
- Single source: NUM_SRC=4, source 2 only, sends bytes 0x11,0x22,0x33,0x44 with s_ready=1 -> one idle cycle, then 4 transfers with s_id=2 and s_first high on 0x11 only. Afterwards busy drops and rr_ptr=3.
- Round-robin contention: all 4 sources continuously valid, BURST_WORDS=1 -> grant order 0,1,2,3,0. Each grant is exactly 4 transfers followed by one bubble cycle, and no bytes interleave between sources.
- Burst hold: BURST_WORDS=2, sources 0 and 1 valid -> source 0 sends 8 bytes, then source 1 sends 8 bytes. word_cnt resets on each grant.
- Backpressure and stall: s_ready toggles 1,0,0,1 mid-word, and m_valid[gnt] drops for 3 cycles after byte 1 -> byte_cnt holds during the stalls and all 4 bytes arrive in order. No other source's m_ready rises.
- Enable drop mid-word: src_en[gnt] cleared after byte 1 -> bytes 2 and 3 still transfer, then release at the boundary. Source is not re-granted while src_en=0, even with m_valid=1.
- Reset mid-word: rstf asserted after byte 2 of source 1 -> s_valid=0, all m_ready=0, s_id=0 immediately. After release, with sources 0 and 1 requesting, the first grant goes to source 0 (rr_ptr=0).
